eth_tx_sched: RTL
=================

Name: eth_tx_sched

Overview:
- Transmit scheduler in front of eth_send, in the i_tx_clk domain.
- Shares the single send datapath between two requesters: source 0 (CPU command send) and source 1 (automatic ARP reply, pulse already synchronised to the tx clock).
- Latches requests, grants them round-robin, issues the one-cycle start strobe, and tracks the frame through o_tx_en.
- Enforces the inter-frame gap and reports completion or timeout for the tx interrupt.

Parameters:
- IFG_CYCLES, 12, idle cycles inserted after tx_en falls before the next grant (minimum 1).
- START_TIMEOUT, 64, cycles to wait after the start strobe for tx_en to rise.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  tx clock (i_tx_clk).
- rst  in  1  asynchronous, active-high reset.
- i_req  in  2  one-cycle request pulses; bit 0 = CPU, bit 1 = ARP reply.
- o_pending  out  2  latched, not-yet-granted requests.
- o_sel  out  1  granted source; drives the eth_send field mux; held from grant until the next grant.
- o_send_en  out  1  one-cycle start strobe to eth_send.
- i_tx_en  in  1  monitored tx_en from eth_send.
- o_busy  out  1  high whenever state != IDLE.
- o_done  out  1  one-cycle pulse when a frame ends (tx_en falls).
- o_done_src  out  1  source of the frame reported by o_done; valid with o_done.
- o_timeout  out  1  one-cycle pulse when tx_en never rose.
- o_frame_cnt  out  CNT_W  frames completed.
- o_timeout_cnt  out  CNT_W  timeouts.

Behaviour:
- Reset values: all outputs 0; pending cleared; round-robin pointer last = 1; state IDLE; counters 0. Reset mid-frame aborts immediately; o_send_en never glitches.
- Pending: pending[i] is set by i_req[i] and cleared on the cycle source i is granted. Set and clear in the same cycle: set wins, so the request stays pending. A pulse on an already-pending source is merged and not counted twice.
- Arbitration, in IDLE only:
  - One bit pending: grant it.
  - Both pending: grant the source != last.
  - Update last to the granted source.
- IDLE -> GRANT: one-cycle latency from the pending bit being visible. o_sel is registered on this transition, so it is stable on the cycle o_send_en is high.
- GRANT: o_send_en = 1 for exactly this cycle; clear the wait counter; go to WAIT_START.
- WAIT_START:
  - i_tx_en = 1 -> BUSY.
  - Otherwise the counter increments; when it reaches START_TIMEOUT-1 without tx_en, pulse o_timeout, increment o_timeout_cnt, go to GAP.
  - tx_en rising in the same cycle the counter expires: tx_en wins, no timeout.
- BUSY: stay while i_tx_en = 1. On i_tx_en = 0: pulse o_done with o_done_src = o_sel, increment o_frame_cnt, go to GAP.
- GAP: count IFG_CYCLES cycles, then go to IDLE. Requests arriving during GAP are latched only.
- Back-to-back timing: the next o_send_en comes no sooner than IFG_CYCLES+2 cycles after the cycle tx_en is first seen low.
- Counters wrap modulo 2^CNT_W with no saturation.

Optional Feature:
- ETH_TX_SCHED_STATS_EN defined: o_frame_cnt and o_timeout_cnt count as described.
- Undefined: both ports are tied to 0 and their registers are removed. Ports remain present so the integration is unchanged.

Decomposition:
- Package eth_tx_sched_pkg holds:
  - typedef enum logic [2:0] tx_state_t: IDLE, GRANT, WAIT_START, BUSY, GAP.
  - typedef enum logic tx_src_t: SRC_CPU = 0, SRC_ARP = 1.
  - Default IFG and timeout constants.
- Sub-module eth_tx_rr_arb contains the pending latches, the last pointer and the grant decision. The FSM and counters stay in eth_tx_sched.

Test Plan:
- Single CPU request: after reset, i_req = 01 at cycle 0 -> o_sel = 0 and o_send_en = 1 at cycle 2. Drive tx_en high for 64 cycles -> o_done one cycle after the fall, o_done_src = 0, o_frame_cnt = 1.
- Simultaneous i_req = 11: grant order is CPU, then ARP, then on a repeat of 11 CPU again. Second o_send_en is exactly IFG_CYCLES+2 = 14 cycles after tx_en first seen low.
- Starvation check: hold ARP pending while CPU pulses every frame -> grants alternate 0,1,0,1 over 4 frames; neither source waits more than one frame.
- Timeout: grant with tx_en held low -> o_timeout pulse 64 cycles after o_send_en, o_done not asserted, o_timeout_cnt = 1, next grant after GAP.
- Merge and collision: pulse ARP twice while it is pending -> only one ARP frame sent. Pulse CPU on its grant cycle -> a second CPU frame follows.
- Reset mid-BUSY: assert rst while tx_en = 1 -> all outputs 0 asynchronously, pending = 00. After release, no o_done for the aborted frame.

Source files
------------

// File: rtl/eth_tx_sched_pkg.sv
// rtl/eth_tx_sched_pkg.sv - shared types and defaults for the tx scheduler
package eth_tx_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        WAIT_START,
        BUSY,
        GAP
    } tx_state_t;

    typedef enum logic {
        SRC_CPU = 1'b0,
        SRC_ARP = 1'b1
    } tx_src_t;

    localparam int DEF_IFG_CYCLES    = 12;
    localparam int DEF_START_TIMEOUT = 64;
    localparam int DEF_CNT_W         = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/eth_tx_rr_arb.sv
// rtl/eth_tx_rr_arb.sv - request latches and two-way round-robin grant decision
module eth_tx_rr_arb
    import eth_tx_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  i_req,
    input  logic        i_arb_en,
    output logic [1:0]  o_pending,
    output logic        o_grant_vld,
    output tx_src_t     o_grant_src
);

    logic [1:0] r_pending;
    tx_src_t    r_last;
    tx_src_t    w_src;
    logic [1:0] w_clr;

    always_comb begin
        w_src = SRC_CPU;
        case (r_pending)
            2'b01:   w_src = SRC_CPU;
            2'b10:   w_src = SRC_ARP;
            2'b11:   w_src = (r_last == SRC_CPU) ? SRC_ARP : SRC_CPU;
            default: w_src = SRC_CPU;
        endcase
    end

    assign o_grant_vld = i_arb_en && (r_pending != 2'b00);
    assign o_grant_src = w_src;
    assign o_pending   = r_pending;
    assign w_clr       = o_grant_vld ? ((w_src == SRC_ARP) ? 2'b10 : 2'b01) : 2'b00;

    // A new pulse on the cycle its source is granted survives the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= 2'b00;
            r_last    <= SRC_ARP;
        end else begin
            r_pending <= (r_pending & ~w_clr) | i_req;
            if (o_grant_vld) r_last <= w_src;
        end
    end

endmodule

// File: rtl/eth_tx_sched.sv
// rtl/eth_tx_sched.sv - tx scheduler FSM; ETH_TX_SCHED_STATS_EN enables statistics counters
module eth_tx_sched
    import eth_tx_sched_pkg::*;
#(
    parameter int IFG_CYCLES    = DEF_IFG_CYCLES,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       i_req,
    output logic [1:0]       o_pending,
    output logic             o_sel,
    output logic             o_send_en,
    input  logic             i_tx_en,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_done_src,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_frame_cnt,
    output logic [CNT_W-1:0] o_timeout_cnt
);

    localparam int TMR_W = $clog2(max_int(IFG_CYCLES, START_TIMEOUT)) + 1;

    tx_state_t        r_state, w_state_nxt;
    tx_src_t          r_sel;
    logic             r_send_en;
    logic [TMR_W-1:0] r_tmr;
    logic             w_tmr_clr, w_tmr_inc, w_done, w_timeout, w_arb_en, w_grant_vld;
    tx_src_t          w_grant_src;

    eth_tx_rr_arb u_arb (
        .clk         (clk),
        .rst         (rst),
        .i_req       (i_req),
        .i_arb_en    (w_arb_en),
        .o_pending   (o_pending),
        .o_grant_vld (w_grant_vld),
        .o_grant_src (w_grant_src)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_clr   = 1'b0;
        w_tmr_inc   = 1'b0;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        w_arb_en    = 1'b0;
        case (r_state)
            IDLE: begin
                w_arb_en = 1'b1;
                if (w_grant_vld) w_state_nxt = GRANT;
            end
            GRANT: begin
                w_tmr_clr   = 1'b1;
                w_state_nxt = WAIT_START;
            end
            WAIT_START: begin
                if (i_tx_en) begin
                    w_state_nxt = BUSY;
                end else if (r_tmr == TMR_W'(START_TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_tmr_clr   = 1'b1;
                    w_state_nxt = GAP;
                end else begin
                    w_tmr_inc = 1'b1;
                end
            end
            BUSY: begin
                if (!i_tx_en) begin
                    w_done      = 1'b1;
                    w_tmr_clr   = 1'b1;
                    w_state_nxt = GAP;
                end
            end
            GAP: begin
                if (r_tmr == TMR_W'(IFG_CYCLES - 1)) w_state_nxt = IDLE;
                else                                 w_tmr_inc   = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Start strobe comes from a flop so eth_send never sees a decode glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_sel     <= SRC_CPU;
            r_send_en <= 1'b0;
            r_tmr     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_send_en <= (w_state_nxt == GRANT);
            if (w_grant_vld) r_sel <= w_grant_src;
            if (w_tmr_clr)      r_tmr <= '0;
            else if (w_tmr_inc) r_tmr <= r_tmr + TMR_W'(1);
        end
    end

    assign o_sel      = r_sel;
    assign o_send_en  = r_send_en;
    assign o_busy     = (r_state != IDLE);
    assign o_done     = w_done;
    assign o_done_src = r_sel;
    assign o_timeout  = w_timeout;

`ifdef ETH_TX_SCHED_STATS_EN
    logic [CNT_W-1:0] r_frame_cnt, r_timeout_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt   <= '0;
            r_timeout_cnt <= '0;
        end else begin
            if (w_done)    r_frame_cnt   <= r_frame_cnt + CNT_W'(1);
            if (w_timeout) r_timeout_cnt <= r_timeout_cnt + CNT_W'(1);
        end
    end

    assign o_frame_cnt   = r_frame_cnt;
    assign o_timeout_cnt = r_timeout_cnt;
`else
    assign o_frame_cnt   = '0;
    assign o_timeout_cnt = '0;
`endif

endmodule
